// File: rtl/vga_term_ctrl.sv
// Terminal write sequencer for a 40x24 character display.
// Owns cursor/start row and is the only writer of the VRAM port.
module vga_term_ctrl #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 24,
    parameter logic [5:0] BLANK = 6'd32
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  din,
    input  logic        clr_req,
    output logic [10:0] vram_w_addr,
    output logic [5:0]  vram_din,
    output logic        vram_w_en,
    output logic [5:0]  h_cursor,
    output logic [4:0]  v_cursor,
    output logic [4:0]  start_row,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    localparam logic [5:0]  H_LAST = 6'(COLS - 1);
    localparam logic [4:0]  R_LAST = 5'(ROWS - 1);
    localparam logic [10:0] S_LAST = 11'(COLS - 1);

    state_t      state, state_n;
    logic [4:0]  row, row_n;
    logic [4:0]  start_n, v_n;
    logic [5:0]  h_n;
    logic [10:0] cnt, cnt_n;
    logic [10:0] addr_n;
    logic [5:0]  vdin_n;
    logic        we_n;
    logic        nl;
    logic        accept;

    assign char_ready = (state == IDLE) & ~clr_req;
    assign accept     = char_valid & char_ready;

    always_comb begin
        state_n = state;
        h_n     = h_cursor;
        row_n   = row;
        start_n = start_row;
        cnt_n   = cnt;
        we_n    = 1'b0;
        addr_n  = vram_w_addr;
        vdin_n  = vram_din;
        nl      = 1'b0;
        if (clr_req) begin
            // a clear request wins over everything, including a live sweep
            state_n = CLEAR;
            h_n     = '0;
            row_n   = '0;
            start_n = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            (din == 8'h0D || din == 8'h8D): begin
                                h_n = '0;
                                nl  = 1'b1;
                            end
                            (din == 8'h00 || din == 8'h0A ||
                             din == 8'h9B || din == 8'h7F): begin
                                h_n = '0;
                            end
                            default: begin
                                we_n   = 1'b1;
                                addr_n = {v_cursor, h_cursor};
                                vdin_n = {~din[6], din[4:0]};
                                if (h_cursor == H_LAST) begin
                                    h_n = '0;
                                    nl  = 1'b1;
                                end else begin
                                    h_n = h_cursor + 6'd1;
                                end
                            end
                        endcase
                    end
                end
                SCROLL: begin
                    we_n   = 1'b1;
                    addr_n = {v_cursor, cnt[5:0]};
                    vdin_n = BLANK;
                    if (cnt == S_LAST) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
                CLEAR: begin
                    we_n   = 1'b1;
                    addr_n = cnt;
                    vdin_n = BLANK;
                    cnt_n  = cnt + 11'd1;
                    if (cnt == 11'h7FF) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (nl) begin
                if (row < R_LAST) begin
                    row_n = row + 5'd1;
                end else begin
                    start_n = start_row + 5'd1;
                    state_n = SCROLL;
                    cnt_n   = '0;
                end
            end
        end
        v_n = start_n + row_n;
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state       <= IDLE;
            h_cursor    <= '0;
            row         <= '0;
            start_row   <= '0;
            v_cursor    <= '0;
            cnt         <= '0;
            vram_w_en   <= 1'b0;
            vram_w_addr <= '0;
            vram_din    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            h_cursor    <= h_n;
            row         <= row_n;
            start_row   <= start_n;
            v_cursor    <= v_n;
            cnt         <= cnt_n;
            vram_w_en   <= we_n;
            vram_w_addr <= addr_n;
            vram_din    <= vdin_n;
            busy        <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_vga_term_ctrl.sv
// Bench for vga_term_ctrl: queue-based write model checked every cycle
// plus directed scenarios with hand-computed literals.
module tb_vga_term_ctrl;
    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  din = 8'h00;
    logic        clr_req = 1'b0;
    logic [10:0] vram_w_addr;
    logic [5:0]  vram_din;
    logic        vram_w_en;
    logic [5:0]  h_cursor;
    logic [4:0]  v_cursor;
    logic [4:0]  start_row;
    logic        busy;

    vga_term_ctrl dut (
        .clk25(clk25), .rst(rst),
        .char_valid(char_valid), .char_ready(char_ready),
        .din(din), .clr_req(clr_req),
        .vram_w_addr(vram_w_addr), .vram_din(vram_din),
        .vram_w_en(vram_w_en), .h_cursor(h_cursor),
        .v_cursor(v_cursor), .start_row(start_row), .busy(busy)
    );

    always #20 clk25 = ~clk25;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // model: cursor as plain integers, pending VRAM writes as a queue
    int m_h = 0, m_row = 0, m_start = 0;
    int q[$];
    bit started = 0;
    bit exp_we = 0;
    int exp_addr = 0, exp_din = 0;

    task automatic model_nl();
        if (m_row < 23) begin
            m_row++;
        end else begin
            m_start = (m_start + 1) % 32;
            for (int c = 0; c < 40; c++)
                q.push_back((((m_start + 23) % 32) * 64 + c) * 64 + 32);
        end
    endtask

    always @(posedge clk25) begin
        logic [7:0] d;
        int e;
        if (started && !rst)
            chk("char_ready", char_ready, (q.size() == 0 && !clr_req));
        exp_we = 0;
        if (rst) begin
            m_h = 0; m_row = 0; m_start = 0;
            q.delete();
            started = 1;
        end else if (started) begin
            if (clr_req) begin
                q.delete();
                for (int a = 0; a < 2048; a++) q.push_back(a * 64 + 32);
                m_h = 0; m_row = 0; m_start = 0;
            end else if (q.size() != 0) begin
                e = q.pop_front();
                exp_we = 1;
                exp_addr = e / 64;
                exp_din = e % 64;
            end else if (char_valid) begin
                d = din;
                if (d == 8'h0D || d == 8'h8D) begin
                    m_h = 0;
                    model_nl();
                end else if (d inside {8'h00, 8'h0A, 8'h9B, 8'h7F}) begin
                    m_h = 0;
                end else begin
                    exp_we = 1;
                    exp_addr = ((m_start + m_row) % 32) * 64 + m_h;
                    exp_din = {26'd0, ~d[6], d[4:0]};
                    m_h++;
                    if (m_h == 40) begin
                        m_h = 0;
                        model_nl();
                    end
                end
            end
        end
        #1;
        if (started) begin
            chk("we", vram_w_en, exp_we);
            chk("h", h_cursor, m_h);
            chk("v", v_cursor, (m_start + m_row) % 32);
            chk("start", start_row, m_start);
            chk("busy", busy, q.size() != 0);
            if (exp_we) begin
                chk("addr", vram_w_addr, exp_addr);
                chk("vdin", vram_din, exp_din);
            end
            if (vram_w_en === 1'b1) n_writes++;
        end
    end

    task automatic send(input logic [7:0] d);
        char_valid = 1'b1;
        din = d;
        @(negedge clk25);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk25);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        int w0, lowcnt, n;
        repeat (2) @(negedge clk25);
        rst = 1'b0;
        chk("rst_h", h_cursor, 0);
        chk("rst_v", v_cursor, 0);
        chk("rst_start", start_row, 0);
        chk("rst_we", vram_w_en, 0);
        chk("rst_addr", vram_w_addr, 0);
        chk("rst_vdin", vram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", char_ready, 1);

        send(8'hC1);
        chk("a_we", vram_w_en, 1);
        chk("a_addr", vram_w_addr, 11'h000);
        chk("a_vdin", vram_din, 6'h01);
        chk("a_h", h_cursor, 1);
        chk("a_ready", char_ready, 1);

        for (int i = 1; i < 40; i++) send(8'hC1 + 8'(i));
        chk("row_last_addr", vram_w_addr, 11'd39);
        chk("row_h", h_cursor, 0);
        chk("row_v", v_cursor, 1);
        chk("row_busy", busy, 0);
        @(negedge clk25);
        chk("row_no_extra", vram_w_en, 0);

        for (int i = 0; i < 22; i++) send(8'h0D);
        chk("r23_v", v_cursor, 23);
        send(8'h8D);
        chk("sc_start", start_row, 1);
        chk("sc_v", v_cursor, 24);
        chk("sc_busy", busy, 1);
        w0 = n_writes;
        lowcnt = 0;
        n = 0;
        while (busy && n < 100) begin
            if (!char_ready) lowcnt++;
            @(negedge clk25);
            n++;
        end
        chk("sc_ready_low", lowcnt, 40);
        chk("sc_writes", n_writes - w0, 40);
        chk("sc_idle", busy, 0);

        for (int i = 0; i < 30; i++) begin
            send(8'h0D);
            wait_idle("scroll_timeout");
        end
        chk("s31_start", start_row, 31);
        chk("s31_v", v_cursor, 22);
        send(8'h0D);
        wait_idle("scroll_timeout");
        chk("wrap_start", start_row, 0);
        chk("wrap_v", v_cursor, 23);
        for (int i = 0; i < 7; i++) begin
            send(8'h0D);
            wait_idle("scroll_timeout");
        end
        chk("s7_start", start_row, 7);
        chk("s7_v", v_cursor, 30);

        w0 = n_writes;
        send(8'h0D);
        repeat (9) @(negedge clk25);
        chk("abort_partial", n_writes - w0, 9);
        w0 = n_writes;
        clr_req = 1'b1;
        @(negedge clk25);
        clr_req = 1'b0;
        wait_idle("clear_timeout");
        chk("clr_writes", n_writes - w0, 2048);
        chk("clr_h", h_cursor, 0);
        chk("clr_v", v_cursor, 0);
        chk("clr_start", start_row, 0);

        for (int i = 0; i < 5; i++) send(8'hC8);
        chk("h5", h_cursor, 5);
        send(8'h9B);
        chk("home_h", h_cursor, 0);
        chk("home_v", v_cursor, 0);
        chk("home_we", vram_w_en, 0);

        clr_req = 1'b1;
        @(negedge clk25);
        clr_req = 1'b0;
        char_valid = 1'b1;
        din = 8'hDA;
        wait_idle("clear2_timeout");
        chk("hold_h", h_cursor, 0);
        @(negedge clk25);
        char_valid = 1'b0;
        chk("hold_h1", h_cursor, 1);
        chk("hold_we", vram_w_en, 1);
        chk("hold_addr", vram_w_addr, 11'h000);
        chk("hold_vdin", vram_din, 6'h1A);

        send(8'h0D);
        for (int i = 0; i < 23; i++) send(8'h0D);
        chk("pre_rst_busy", busy, 1);
        repeat (5) @(negedge clk25);
        rst = 1'b1;
        @(negedge clk25);
        chk("mid_rst_we", vram_w_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", start_row, 0);
        chk("mid_rst_v", v_cursor, 0);
        rst = 1'b0;
        @(negedge clk25);
        chk("post_rst_we", vram_w_en, 0);
        chk("post_rst_ready", char_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
